// File: rtl/regread_bypass_lane_if.sv
// Issue-side, PRF-side, writeback and execute-side signals of one register-read lane.
// bypass_hits_o exists only when REGREAD_BYPASS_STATS_EN is defined.
interface regread_bypass_lane_if #(
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 64,
  parameter int WB_PORTS  = 4,
  parameter int PAYLOAD_W = 32
);
  logic                         flush_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [TAG_W-1:0]             src1_tag_i;
  logic [TAG_W-1:0]             src2_tag_i;
  logic                         src1_use_i;
  logic                         src2_use_i;
  logic [PAYLOAD_W-1:0]         payload_i;
  logic [TAG_W-1:0]             prf_addr0_o;
  logic [TAG_W-1:0]             prf_addr1_o;
  logic [DATA_W-1:0]            prf_data0_i;
  logic [DATA_W-1:0]            prf_data1_i;
  logic [WB_PORTS-1:0]          wb_we_i;
  logic [WB_PORTS*TAG_W-1:0]    wb_tag_i;
  logic [WB_PORTS*DATA_W-1:0]   wb_data_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [DATA_W-1:0]            opnd1_o;
  logic [DATA_W-1:0]            opnd2_o;
  logic [PAYLOAD_W-1:0]         payload_o;
`ifdef REGREAD_BYPASS_STATS_EN
  logic [31:0]                  bypass_hits_o;
`endif

  // Lane view: everything except the outputs below is driven from outside.
  modport slave (
    input  flush_i, in_valid_i, src1_tag_i, src2_tag_i, src1_use_i, src2_use_i,
           payload_i, prf_data0_i, prf_data1_i, wb_we_i, wb_tag_i, wb_data_i,
           out_ready_i,
    output in_ready_o, prf_addr0_o, prf_addr1_o, out_valid_o, opnd1_o, opnd2_o,
           payload_o
`ifdef REGREAD_BYPASS_STATS_EN
    , output bypass_hits_o
`endif
  );

  modport master (
    output flush_i, in_valid_i, src1_tag_i, src2_tag_i, src1_use_i, src2_use_i,
           payload_i, prf_data0_i, prf_data1_i, wb_we_i, wb_tag_i, wb_data_i,
           out_ready_i,
    input  in_ready_o, prf_addr0_o, prf_addr1_o, out_valid_o, opnd1_o, opnd2_o,
           payload_o
`ifdef REGREAD_BYPASS_STATS_EN
    , input bypass_hits_o
`endif
  );
endinterface

// File: rtl/regread_bypass_lane.sv
// Register-read stage: PRF addressing, same-cycle writeback bypass, valid/ready output register.
// Optional bypass-hit counter enabled by REGREAD_BYPASS_STATS_EN.
module regread_bypass_lane #(
  parameter int PHYS_REGS = 96,
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 64,
  parameter int WB_PORTS  = 4,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regread_bypass_lane_if.slave bus
);

  // Handshake: a transfer into the stage happens when in_valid_i && in_ready_o && !flush_i;
  // a transfer out happens when out_valid_o && out_ready_i. Flush squashes the output register.

  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    opnd1_q, opnd2_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [DATA_W-1:0]    opnd1_d, opnd2_d;
  logic                 hit1, hit2;
  logic                 accept;

  // Returns {hit, operand}; iterating high-to-low lets the lowest matching port win.
  function automatic logic [DATA_W:0] resolve(
    input logic [TAG_W-1:0]           tag,
    input logic                       use_src,
    input logic [DATA_W-1:0]          prf,
    input logic [WB_PORTS-1:0]        we,
    input logic [WB_PORTS*TAG_W-1:0]  tags,
    input logic [WB_PORTS*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = {1'b0, prf};
    for (int k = WB_PORTS - 1; k >= 0; k--) begin
      if (we[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, data[k*DATA_W +: DATA_W]};
      end
    end
    if (!use_src) begin
      r = '0;
    end
    return r;
  endfunction

  assign bus.prf_addr0_o = bus.src1_tag_i;
  assign bus.prf_addr1_o = bus.src2_tag_i;

  assign {hit1, opnd1_d} = resolve(bus.src1_tag_i, bus.src1_use_i, bus.prf_data0_i,
                                   bus.wb_we_i, bus.wb_tag_i, bus.wb_data_i);
  assign {hit2, opnd2_d} = resolve(bus.src2_tag_i, bus.src2_use_i, bus.prf_data1_i,
                                   bus.wb_we_i, bus.wb_tag_i, bus.wb_data_i);

  assign bus.in_ready_o = !valid_q || bus.out_ready_i;
  assign accept         = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;

  always_comb begin
    valid_d = valid_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (bus.out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      opnd1_q   <= '0;
      opnd2_q   <= '0;
      payload_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        opnd1_q   <= opnd1_d;
        opnd2_q   <= opnd2_d;
        payload_q <= bus.payload_i;
      end
    end
  end

  assign bus.out_valid_o = valid_q;
  assign bus.opnd1_o     = opnd1_q;
  assign bus.opnd2_o     = opnd2_q;
  assign bus.payload_o   = payload_q;

`ifdef REGREAD_BYPASS_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [32:0] hits_sum;

  assign hits_sum = {1'b0, hits_q} + {31'b0, hit1} + {31'b0, hit2};

  always_comb begin
    hits_d = hits_q;
    if (accept) begin
      hits_d = hits_sum[32] ? 32'hFFFF_FFFF : hits_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign bus.bypass_hits_o = hits_q;
`else
  logic unused_hits;
  assign unused_hits = hit1 ^ hit2;
`endif

`ifndef SYNTHESIS
  logic wb_dup;

  always_comb begin
    wb_dup = 1'b0;
    for (int i = 0; i < WB_PORTS; i++) begin
      for (int j = i + 1; j < WB_PORTS; j++) begin
        if (bus.wb_we_i[i] && bus.wb_we_i[j] &&
            (bus.wb_tag_i[i*TAG_W +: TAG_W] == bus.wb_tag_i[j*TAG_W +: TAG_W])) begin
          wb_dup = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!wb_dup)
        else $warning("regread_bypass_lane: duplicate writeback tags in one cycle");
      assert (!accept || ((!bus.src1_use_i || int'(bus.src1_tag_i) < PHYS_REGS) &&
                          (!bus.src2_use_i || int'(bus.src2_tag_i) < PHYS_REGS)))
        else $error("regread_bypass_lane: source tag beyond PHYS_REGS");
    end
  end
`endif

endmodule
